aes128_iter_ctrl: RTL and testbench

AES128_ITER_CTRL -- requirements
Module: aes128_iter_ctrl

---
 rtl/aes128_iter_ctrl.sv | 135 +++++++++++++
 tb/tb_aes128_iter_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 encryption controller: sequences ten rounds through an external
// round stage of ROUND_LAT cycles. Optional macro AES_CTRL_LAST_KEY_EN adds last_key.
module aes128_iter_ctrl #(
  parameter int ROUND_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic [127:0] pt_in,
  output logic         ready,
  output logic         done,
  output logic [127:0] ct_out,
  output logic [3:0]   rnd_rc,
  output logic [127:0] rnd_key,
  output logic [127:0] rnd_state,
  input  logic [127:0] rnd_result,
  input  logic [127:0] rnd_keyout,
`ifdef AES_CTRL_LAST_KEY_EN
  output logic [127:0] last_key,
`endif
  output logic [1:0]   state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] LAT      = 3'(ROUND_LAT);
  localparam logic [3:0] LAST_RND = 4'd9;

  logic [1:0]   fsm_q, fsm_d;
  logic [127:0] key_cap_q, key_cap_d;
  logic [127:0] pt_cap_q, pt_cap_d;
  logic [127:0] state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   rc_q, rc_d;
  logic [2:0]   wait_q, wait_d;
  logic [127:0] ct_q, ct_d;
`ifdef AES_CTRL_LAST_KEY_EN
  logic [127:0] last_key_q, last_key_d;
`endif

  always_comb begin
    fsm_d     = fsm_q;
    key_cap_d = key_cap_q;
    pt_cap_d  = pt_cap_q;
    state_d   = state_q;
    key_d     = key_q;
    rc_d      = rc_q;
    wait_d    = wait_q;
    ct_d      = ct_q;
`ifdef AES_CTRL_LAST_KEY_EN
    last_key_d = last_key_q;
`endif
    case (fsm_q)
      S_IDLE: begin
        if (start) begin
          key_cap_d = key_in;
          pt_cap_d  = pt_in;
          fsm_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        // Initial AddRoundKey happens here so round 0 of the stage starts from pt ^ key.
        state_d = pt_cap_q ^ key_cap_q;
        key_d   = key_cap_q;
        rc_d    = 4'd0;
        wait_d  = 3'd0;
        fsm_d   = S_RUN;
      end
      S_RUN: begin
        if (wait_q == LAT) begin
          state_d = rnd_result;
          key_d   = rnd_keyout;
          wait_d  = 3'd0;
          if (rc_q == LAST_RND) begin
            ct_d  = rnd_result;
`ifdef AES_CTRL_LAST_KEY_EN
            last_key_d = rnd_keyout;
`endif
            fsm_d = S_DONE;
          end else begin
            rc_d = rc_q + 4'd1;
          end
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      S_DONE: fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= S_IDLE;
      key_cap_q <= '0;
      pt_cap_q  <= '0;
      state_q   <= '0;
      key_q     <= '0;
      rc_q      <= '0;
      wait_q    <= '0;
      ct_q      <= '0;
`ifdef AES_CTRL_LAST_KEY_EN
      last_key_q <= '0;
`endif
    end else begin
      fsm_q     <= fsm_d;
      key_cap_q <= key_cap_d;
      pt_cap_q  <= pt_cap_d;
      state_q   <= state_d;
      key_q     <= key_d;
      rc_q      <= rc_d;
      wait_q    <= wait_d;
      ct_q      <= ct_d;
`ifdef AES_CTRL_LAST_KEY_EN
      last_key_q <= last_key_d;
`endif
    end
  end

  assign ready     = (fsm_q == S_IDLE);
  assign done      = (fsm_q == S_DONE);
  assign ct_out    = ct_q;
  assign rnd_rc    = rc_q;
  assign rnd_key   = key_q;
  assign rnd_state = state_q;
  assign state_dbg = fsm_q;
`ifdef AES_CTRL_LAST_KEY_EN
  assign last_key  = last_key_q;
`endif

endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// Bench for aes128_iter_ctrl: two instances (ROUND_LAT 1 and 3), each with a behavioural
// AES round stage, driven by shared stimulus and checked by a ciphertext scoreboard.
module tb_aes128_iter_ctrl;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
  localparam int DONE_A = 2 + 10 * (LAT_A + 1);
  localparam int DONE_B = 2 + 10 * (LAT_B + 1);

  localparam logic [127:0] K0   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P0   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C0   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] S0   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] S1   = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] LK0  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start;
  logic [127:0] key_in, pt_in;
  int           cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         ready_a, done_a, ready_b, done_b;
  logic [127:0] ct_a, rkey_a, rstate_a, rres_a, rkout_a;
  logic [127:0] ct_b, rkey_b, rstate_b, rres_b, rkout_b;
  logic [3:0]   rc_a, rc_b;
  logic [1:0]   dbg_a, dbg_b;
`ifdef AES_CTRL_LAST_KEY_EN
  logic [127:0] lk_a, lk_b;
`endif

  aes128_iter_ctrl #(.ROUND_LAT(LAT_A)) dut_a (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .pt_in(pt_in),
    .ready(ready_a), .done(done_a), .ct_out(ct_a), .rnd_rc(rc_a),
    .rnd_key(rkey_a), .rnd_state(rstate_a), .rnd_result(rres_a), .rnd_keyout(rkout_a),
`ifdef AES_CTRL_LAST_KEY_EN
    .last_key(lk_a),
`endif
    .state_dbg(dbg_a)
  );

  aes128_iter_ctrl #(.ROUND_LAT(LAT_B)) dut_b (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .pt_in(pt_in),
    .ready(ready_b), .done(done_b), .ct_out(ct_b), .rnd_rc(rc_b),
    .rnd_key(rkey_b), .rnd_state(rstate_b), .rnd_result(rres_b), .rnd_keyout(rkout_b),
`ifdef AES_CTRL_LAST_KEY_EN
    .last_key(lk_b),
`endif
    .state_dbg(dbg_b)
  );

  // ---------------- AES arithmetic (GF(2^8), S-box derived from inverses) ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, r, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv;
      r = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      sbox[x] = s ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [3:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < int'(rc); i++) rcon = xt(rcon);
    {w0, w1, w2, w3} = k;
    t  = {sbox[w3[23:16]], sbox[w3[15:8]], sbox[w3[7:0]], sbox[w3[31:24]]} ^ {rcon, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] rk,
                                             input bit last);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   m [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[4*c+r] = a[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      m[4*c+0] = gmul(8'h02, b[4*c]) ^ gmul(8'h03, b[4*c+1]) ^ b[4*c+2] ^ b[4*c+3];
      m[4*c+1] = b[4*c] ^ gmul(8'h02, b[4*c+1]) ^ gmul(8'h03, b[4*c+2]) ^ b[4*c+3];
      m[4*c+2] = b[4*c] ^ b[4*c+1] ^ gmul(8'h02, b[4*c+2]) ^ gmul(8'h03, b[4*c+3]);
      m[4*c+3] = gmul(8'h03, b[4*c]) ^ b[4*c+1] ^ b[4*c+2] ^ gmul(8'h02, b[4*c+3]);
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = last ? b[i] : m[i];
    return o ^ rk;
  endfunction

  task automatic aes_ref(input logic [127:0] k, input logic [127:0] p,
                         output logic [127:0] ct, output logic [127:0] lk);
    logic [127:0] s, kk;
    s  = p ^ k;
    kk = k;
    for (int r = 0; r < 10; r++) begin
      kk = key_exp(kk, 4'(r));
      s  = enc_round(s, kk, r == 9);
    end
    ct = s;
    lk = kk;
  endtask

  // ---------------- Round stages: result valid ROUND_LAT edges after inputs ----------------
  logic [127:0] pa_res [8];
  logic [127:0] pa_key [8];
  logic [127:0] pb_res [8];
  logic [127:0] pb_key [8];

  always @(posedge clk) begin
    pa_key[0] <= key_exp(rkey_a, rc_a);
    pa_res[0] <= enc_round(rstate_a, key_exp(rkey_a, rc_a), rc_a == 4'd9);
    pb_key[0] <= key_exp(rkey_b, rc_b);
    pb_res[0] <= enc_round(rstate_b, key_exp(rkey_b, rc_b), rc_b == 4'd9);
    for (int i = 1; i < 8; i++) begin
      pa_res[i] <= pa_res[i-1];
      pa_key[i] <= pa_key[i-1];
      pb_res[i] <= pb_res[i-1];
      pb_key[i] <= pb_key[i-1];
    end
  end
  assign rres_a  = pa_res[LAT_A-1];
  assign rkout_a = pa_key[LAT_A-1];
  assign rres_b  = pb_res[LAT_B-1];
  assign rkout_b = pb_key[LAT_B-1];

  // ---------------- Scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [127:0] exp_q_a[$], exp_lk_a[$], exp_q_b[$], exp_lk_b[$];
  int           exp_t_a[$], exp_t_b[$];
  logic [127:0] last_ct_exp;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // done must match a pending accepted operation; a reset abandons anything pending.
  always @(negedge clk) begin
    if (done_a) begin
      if (exp_q_a.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL a_unexpected_done: got done=1 at cycle %0d, expected no done", cyc);
      end else begin
        check("a_ct_out", ct_a, exp_q_a.pop_front());
        check("a_done_latency", 128'(cyc - exp_t_a.pop_front()), 128'(DONE_A));
`ifdef AES_CTRL_LAST_KEY_EN
        check("a_last_key", lk_a, exp_lk_a.pop_front());
`else
        void'(exp_lk_a.pop_front());
`endif
      end
    end
    if (done_b) begin
      if (exp_q_b.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b_unexpected_done: got done=1 at cycle %0d, expected no done", cyc);
      end else begin
        check("b_ct_out", ct_b, exp_q_b.pop_front());
        check("b_done_latency", 128'(cyc - exp_t_b.pop_front()), 128'(DONE_B));
`ifdef AES_CTRL_LAST_KEY_EN
        check("b_last_key", lk_b, exp_lk_b.pop_front());
`else
        void'(exp_lk_b.pop_front());
`endif
      end
    end
    if (rst) begin
      exp_q_a.delete(); exp_t_a.delete(); exp_lk_a.delete();
      exp_q_b.delete(); exp_t_b.delete(); exp_lk_b.delete();
    end
  end

  // ---------------- Driver tasks ----------------
  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!(ready_a && ready_b)) begin
      @(posedge clk); #1;
      n++;
      if (n > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL wait_idle_timeout: got ready_a=%0b ready_b=%0b, expected both 1", ready_a, ready_b);
        break;
      end
    end
  endtask

  task automatic goto(input int t0, input int n);
    while (cyc != t0 + n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_start(input logic [127:0] k, input logic [127:0] p, output int t0);
    logic [127:0] ct, lk;
    wait_idle();
    aes_ref(k, p, ct, lk);
    key_in = k;
    pt_in  = p;
    start  = 1'b1;
    t0     = cyc;
    last_ct_exp = ct;
    exp_q_a.push_back(ct); exp_t_a.push_back(t0); exp_lk_a.push_back(lk);
    exp_q_b.push_back(ct); exp_t_b.push_back(t0); exp_lk_b.push_back(lk);
    @(posedge clk); #1;
    start  = 1'b0;
    key_in = rand128();
    pt_in  = rand128();
  endtask

  task automatic pulse_start(input int t0, input int n);
    goto(t0, n);
    start  = 1'b1;
    key_in = rand128();
    pt_in  = rand128();
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  // ---------------- Main sequence ----------------
  initial begin
    int t0;
    rst = 1'b1;
    start = 1'b0;
    key_in = '0;
    pt_in = '0;
    build_sbox();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("a_reset_ready", 128'(ready_a), 128'(1));
    check("a_reset_done", 128'(done_a), 128'(0));
    check("a_reset_ct", ct_a, '0);
    check("a_reset_rnd_state", rstate_a, '0);
    check("a_reset_rnd_key", rkey_a, '0);
    check("a_reset_rnd_rc", 128'(rc_a), 128'(0));
    check("b_reset_ready", 128'(ready_b), 128'(1));
    check("b_reset_ct", ct_b, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Known-answer vector with round-boundary probes
    do_start(K0, P0, t0);
    goto(t0, 2); @(negedge clk);
    check("a_run0_rnd_state", rstate_a, S0);
    check("a_run0_rnd_rc", 128'(rc_a), 128'(0));
    check("a_run0_rnd_key", rkey_a, K0);
    check("b_run0_rnd_state", rstate_b, S0);
    goto(t0, 3); @(negedge clk);
    check("a_run0_stable_state", rstate_a, S0);
    check("a_run0_stable_rc", 128'(rc_a), 128'(0));
    goto(t0, 4); @(negedge clk);
    check("a_rnd1_state", rstate_a, S1);
    check("a_rnd1_key", rkey_a, RK1);
    check("a_rnd1_rc", 128'(rc_a), 128'(1));
    check("b_rnd0_hold_state", rstate_b, S0);
    goto(t0, 6); @(negedge clk);
    check("b_rnd1_state", rstate_b, S1);
    check("b_rnd1_key", rkey_b, RK1);
    wait_idle();
    check("a_kat_ct", ct_a, C0);
    check("b_kat_ct", ct_b, C0);
`ifdef AES_CTRL_LAST_KEY_EN
    check("a_kat_last_key", lk_a, LK0);
    check("b_kat_last_key", lk_b, LK0);
`endif

    // Starts while busy are ignored
    do_start(K0, P0, t0);
    pulse_start(t0, 5);
    pulse_start(t0, 21);
    wait_idle();
    check("a_ignored_start_ct", ct_a, C0);
    check("b_ignored_start_ct", ct_b, C0);

    // Reset mid-operation abandons it
    do_start(rand128(), rand128(), t0);
    goto(t0, 9);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("a_abort_ready", 128'(ready_a), 128'(1));
    check("a_abort_ct", ct_a, '0);
    check("a_abort_done", 128'(done_a), 128'(0));
    check("b_abort_ready", 128'(ready_b), 128'(1));
    check("b_abort_ct", ct_b, '0);
    do_start(K0, P0, t0);
    wait_idle();
    check("a_post_abort_ct", ct_a, C0);

    // Random operations with random idle gaps
    for (int i = 0; i < 6; i++) begin
      do_start(rand128(), rand128(), t0);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        key_in = rand128();
        pt_in  = rand128();
      end
    end
    wait_idle();

    // ct_out holds while inputs churn in IDLE
    repeat (5) begin
      @(posedge clk); #1;
      key_in = rand128();
      pt_in  = rand128();
    end
    @(negedge clk);
    check("a_ct_hold", ct_a, last_ct_exp);
    check("b_ct_hold", ct_b, last_ct_exp);
    check("a_pending_empty", 128'(exp_q_a.size()), 128'(0));
    check("b_pending_empty", 128'(exp_q_b.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_checks++;
    n_fail++;
    $display("FAIL global_timeout: got no completion at cycle %0d, expected finish", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
